// File: rtl/led_seq_pkg.sv
// Shared encodings and the LED pattern decode for the LED sequencer.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package led_seq_pkg;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // LED image for a (mode, position) pair; callers keep the low WIDTH bits.
  // FILL is computed one bit wider so pos=31 yields all-ones without overflow.
  function automatic logic [31:0] led_pattern(input logic [1:0] mode,
                                              input logic [4:0] pos);
    logic [32:0] fill;
    fill = (33'd2 << pos) - 33'd1;
    case (mode)
      MODE_FILL:  led_pattern = fill[31:0];
      MODE_BLINK: led_pattern = (pos == 5'd0) ? 32'hFFFF_FFFF : 32'h0;
      default:    led_pattern = 32'd1 << pos;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Step-period prescaler: counts i_clk cycles and emits a tick every i_div+1
// cycles. The >= compare means a lowered i_div fires immediately instead of
// waiting for the counter to wrap.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_pause,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt >= i_div) && !i_pause;

  // Count up between ticks, restart on tick, hold while paused.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_cnt <= '0;
    else if (o_tick)  r_cnt <= '0;
    else if (!i_pause) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: BOUNCE / ROTATE / FILL / BLINK patterns advanced at
// a programmable step rate. o_led, o_step and o_wrap are all registered and
// change together on the edge that consumes a tick.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH = `DEFAULT_WIDTH,
  parameter int DIV_W = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_mode,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_led,
  output logic             o_step,
  output logic             o_wrap
);

  localparam int            PW      = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

  logic          w_tick;
  logic          w_mode_chg;
  logic          w_wrap;
  logic [PW-1:0] w_pos_nxt;
  logic          w_dir_nxt;
  logic [31:0]   w_pat;
  logic [PW-1:0] r_pos;
  logic          r_dir;
  logic [1:0]    r_mode;

  led_prescaler #(.DIV_W(DIV_W)) u_pre (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_div   (i_div),
    .i_pause (i_pause),
    .o_tick  (w_tick)
  );

  // A mode request only matters when a tick samples it.
  assign w_mode_chg = (i_mode != r_mode);

  // Next position/direction for the current mode, or restart on mode change.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (w_mode_chg) begin
      w_pos_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else begin
      case (r_mode)
        MODE_BOUNCE: begin
          w_pos_nxt = (r_dir == DIR_UP) ? r_pos + 1'b1 : r_pos - 1'b1;
          if (w_pos_nxt == POS_MAX)  w_dir_nxt = DIR_DOWN;
          else if (w_pos_nxt == '0)  w_dir_nxt = DIR_UP;
        end
        MODE_BLINK: w_pos_nxt = (r_pos == '0) ? PW'(1) : '0;
        default:    w_pos_nxt = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
      endcase
    end
  end

  // Without a mode change i_mode equals r_mode, so i_mode is the next mode.
  assign w_pat  = led_pattern(i_mode, 5'(w_pos_nxt));
  assign w_wrap = !w_mode_chg && (r_pos != '0) && (w_pos_nxt == '0);

  // Pattern state and registered outputs; everything advances only on tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos  <= '0;
      r_dir  <= DIR_UP;
      r_mode <= MODE_BOUNCE;
      o_led  <= WIDTH'(1);
      o_step <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_step <= w_tick;
      o_wrap <= w_tick && w_wrap;
      if (w_tick) begin
        r_pos  <= w_pos_nxt;
        r_dir  <= w_dir_nxt;
        r_mode <= i_mode;
        o_led  <= w_pat[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed step results; monitors pop
// and compare whenever a DUT raises o_step.
module tb_led_sequencer;

  typedef struct packed { logic [7:0] led; logic wrap; } exp8_t;
  typedef struct packed { logic [1:0] led; logic wrap; } exp2_t;

  logic        clk = 1'b0;
  logic        rst8, pause8, rst2, pause2;
  logic [23:0] div8, div2;
  logic [1:0]  mode8, mode2;
  logic [7:0]  led8;
  logic [1:0]  led2;
  logic        step8, wrap8, step2, wrap2;

  exp8_t q8[$];
  exp2_t q2[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_step = -1;
  bit    chk_gap = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_sequencer #(.WIDTH(8), .DIV_W(24)) dut8 (
    .i_clk(clk), .i_reset(rst8), .i_div(div8), .i_mode(mode8), .i_pause(pause8),
    .o_led(led8), .o_step(step8), .o_wrap(wrap8));

  led_sequencer #(.WIDTH(2), .DIV_W(24)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_div(div2), .i_mode(mode2), .i_pause(pause2),
    .o_led(led2), .o_step(step2), .o_wrap(wrap2));

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push8(input logic [7:0] led, input logic wrap);
    exp8_t e;
    e.led = led; e.wrap = wrap;
    q8.push_back(e);
  endfunction

  // WIDTH=8 monitor: every step must match the next expected entry.
  always @(negedge clk) begin
    exp8_t e;
    if (step8 === 1'b1) begin
      if (q8.size() == 0) chk("step8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("led8", {24'd0, led8}, {24'd0, e.led});
        chk("wrap8", {31'd0, wrap8}, {31'd0, e.wrap});
      end
      if (chk_gap && last_step >= 0) chk("step8_gap", cyc - last_step, 32'd4);
      last_step = cyc;
    end else if (wrap8 === 1'b1) chk("wrap8_without_step", 32'd1, 32'd0);
  end

  // WIDTH=2 monitor.
  always @(negedge clk) begin
    exp2_t e;
    if (step2 === 1'b1) begin
      if (q2.size() == 0) chk("step2_unexpected", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("led2", {30'd0, led2}, {30'd0, e.led});
        chk("wrap2", {31'd0, wrap2}, {31'd0, e.wrap});
      end
    end
  end

  // Inputs change 1 time unit after the falling edge, after the monitors.
  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl[];
    rst8 = 1; pause8 = 0; div8 = 0; mode8 = 0;
    rst2 = 1; pause2 = 0; div2 = 0; mode2 = 0;
    run(2);
    chk("rst_led", {24'd0, led8}, 32'h01);
    chk("rst_step", {31'd0, step8}, 32'd0);
    chk("rst_wrap", {31'd0, wrap8}, 32'd0);

    // BOUNCE, tick every cycle: 14-step round trip, wrap on return to 01.
    rst8 = 0;
    tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    foreach (tbl[i]) push8(tbl[i], i == 13);
    run(14);
    chk("bounce_drained", q8.size(), 32'd0);

    // FILL: mode change shows 01 without wrap, then wrap only on FF -> 01.
    mode8 = 2;
    tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    foreach (tbl[i]) push8(tbl[i], i == 8);
    run(9);
    chk("fill_drained", q8.size(), 32'd0);

    // ROTATE with i_div=3: one step every 4 cycles, 80 -> 01 wraps.
    mode8 = 1; div8 = 3; chk_gap = 1; last_step = -1;
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    foreach (tbl[i]) push8(tbl[i], i == 8);
    run(36);
    chk_gap = 0;
    chk("rotate_drained", q8.size(), 32'd0);

    // Pause mid-count (cnt=2): frozen outputs, then two cycles to the tick.
    run(2);
    pause8 = 1;
    for (int i = 0; i < 10; i++) begin
      run(1);
      chk("pause_led", {24'd0, led8}, 32'h01);
      chk("pause_step", {31'd0, step8}, 32'd0);
    end
    chk("pause_cnt", {8'd0, dut8.u_pre.r_cnt}, 32'd2);
    pause8 = 0;
    push8(8'h02, 1'b0);
    run(1);
    chk("resume_no_step", {31'd0, step8}, 32'd0);
    run(1);
    chk("resume_drained", q8.size(), 32'd0);

    // BOUNCE to pos 5, then BLINK: FF, 00, FF(wrap), 00, FF(wrap).
    div8 = 0; mode8 = 0;
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    foreach (tbl[i]) push8(tbl[i], 1'b0);
    run(6);
    mode8 = 3;
    tbl = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    foreach (tbl[i]) push8(tbl[i], i == 2 || i == 4);
    run(5);
    chk("blink_drained", q8.size(), 32'd0);

    // BOUNCE to pos 6 moving down, then reset mid-count.
    mode8 = 0;
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    foreach (tbl[i]) push8(tbl[i], 1'b0);
    run(9);
    chk("pos6_drained", q8.size(), 32'd0);
    div8 = 5;
    run(2);
    rst8 = 1;
    run(1);
    chk("midrst_led", {24'd0, led8}, 32'h01);
    chk("midrst_step", {31'd0, step8}, 32'd0);
    chk("midrst_wrap", {31'd0, wrap8}, 32'd0);
    chk("midrst_cnt", {8'd0, dut8.u_pre.r_cnt}, 32'd0);
    // First tick after reset with ROTATE selected is a mode change.
    rst8 = 0; mode8 = 1;
    push8(8'h01, 1'b0);
    run(5);
    chk("postrst_pending", q8.size(), 32'd1);
    run(1);
    chk("postrst_drained", q8.size(), 32'd0);
    rst8 = 1;

    // WIDTH=2 BOUNCE alternates 01/02, wrap on each 02 -> 01.
    rst2 = 0;
    for (int i = 0; i < 6; i++) begin
      exp2_t e;
      e.led = (i % 2 == 0) ? 2'b10 : 2'b01;
      e.wrap = (i % 2 == 1);
      q2.push_back(e);
    end
    run(6);
    chk("w2_drained", q2.size(), 32'd0);
    chk("w2_led_end", {30'd0, led2}, 32'h1);
    rst2 = 1;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
